regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port register file for the pipelined CPU datapath; successor to the single-write, two-read 32x32 register file.
- Generalises width, depth, read-port count and write-port count.
- Adds:
  - write-to-read bypass, so decode sees same-cycle writeback without a negedge-write trick;
  - a per-register busy scoreboard for hazard detection;
  - a sequenced clear after reset;
  - a flattened debug snapshot.

Parameters:
- DATA_W, 32, width of each register.
- NREGS, 32, number of registers; power of two, at least 2.
- ADDR_W, $clog2(NREGS), register address width (derived).
- NUM_READ, 2, number of combinational read ports.
- NUM_WRITE, 2, number of write ports.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ready  out  1  high when the init sweep is done and the file accepts traffic.
- rd_addr  in  NUM_READ*ADDR_W  read addresses; port p uses slice [p*ADDR_W +: ADDR_W].
- rd_data  out  NUM_READ*DATA_W  read data, with bypass applied.
- rd_busy  out  NUM_READ  scoreboard bit for each read address, with bypass applied.
- wr_en  in  NUM_WRITE  per-port write enable.
- wr_addr  in  NUM_WRITE*ADDR_W  write addresses.
- wr_data  in  NUM_WRITE*DATA_W  write data.
- busy_set_en  in  1  issue stage marks a destination register pending.
- busy_set_addr  in  ADDR_W  destination register to mark pending.
- reg_content  out  NREGS*DATA_W  debug snapshot; register j at [j*DATA_W +: DATA_W], registered values only, no bypass.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - state=INIT, clr_cnt=0, ready=0.
  - rd_data=0, rd_busy=0, reg_content=0 (array cleared by the sweep; reg_content is 0 once INIT ends).
- FSM states INIT and RUN:
  - INIT: each cycle write 0 to mem[clr_cnt] and clear busy[clr_cnt], then clr_cnt++.
  - INIT -> RUN on the cycle clr_cnt == NREGS-1.
  - ready rises exactly NREGS cycles after the first cycle rst is sampled low.
  - While INIT: wr_en and busy_set_en are ignored; rd_data and rd_busy are forced to 0.
- Reset mid-operation: rst high in any state returns the FSM to INIT with clr_cnt=0 on the next edge. All contents are cleared again; no partial state survives.
- Register 0:
  - Reads always return 0 with rd_busy=0.
  - Writes and busy sets to address 0 are discarded.
- Writes (RUN only):
  - mem[wr_addr[w]] <= wr_data[w] on the rising edge when wr_en[w] is set and the address is not 0.
  - Same-address collision between ports: the highest-index enabled port wins; lower ports are dropped silently.
- Bypass: rd_data[p] is a combinational choice between the highest-index enabled write port whose address matches rd_addr[p] (non-zero) and mem[rd_addr[p]]. Read-after-write therefore costs zero cycles.
- Scoreboard:
  - busy[a] is set when busy_set_en and busy_set_addr==a (a not 0).
  - busy[a] is cleared when any enabled write port targets a.
  - Set and clear of the same address in the same cycle: set wins (a new producer was issued).
  - rd_busy[p] = busy[rd_addr[p]] AND NOT (some enabled write to rd_addr[p] this cycle).
- Latency: reads and rd_busy are combinational. Writes and busy updates become visible in the registered state one edge later; they are visible immediately through bypass.
- Widths: no arithmetic beyond clr_cnt, which is ADDR_W bits and stops at NREGS-1 (no wrap).

Decomposition:
- Shared package regfile_pkg:
  - FSM state enum {INIT, RUN};
  - a helper function for slicing flattened port vectors.
- One natural sub-module, regfile_fwd_sel: a per-read-port priority mux over the write ports. It returns the hit flag and the forwarded data; one instance per read port.

Test Plan:
- Reset, then rst low -> ready=0 for 32 cycles, ready=1 on cycle 32; rd_data=0 throughout. Writes attempted in INIT are absent afterwards.
- Write r5=0xDEADBEEF on port 0 while reading r5 in the same cycle -> rd_data[0]=0xDEADBEEF that cycle; reg_content[5] shows it after the edge.
- Ports 0 and 1 both write r7 (0x11111111 and 0x22222222) -> mem[7]=0x22222222; the same-cycle bypass read also gives 0x22222222.
- Write r0=0xFFFFFFFF and busy_set r0 -> reads of r0 give 0 with rd_busy=0.
- Scoreboard sequence:
  - busy_set r3 at cycle n -> rd_busy=1 from n+1.
  - Write r3 at cycle m -> rd_busy=0 during m (bypass) and after.
  - busy_set r3 together with a write to r3 -> rd_busy=1 next cycle.
- After writing r1..r4, pulse rst mid-RUN -> ready drops next edge; after 32 cycles all registers read 0 and ready=1.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Low bit of element idx inside a flattened vector of width-bit elements.
  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/regfile_fwd_sel.sv
// Write-to-read forwarding mux for one read port; highest-index matching write port wins.
module regfile_fwd_sel
  import regfile_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int NUM_WRITE = 2
) (
  input  logic [ADDR_W-1:0]           rd_addr_i,
  input  logic [NUM_WRITE-1:0]        wr_en_i,
  input  logic [NUM_WRITE*ADDR_W-1:0] wr_addr_i,
  input  logic [NUM_WRITE*DATA_W-1:0] wr_data_i,
  output logic                        hit_o,
  output logic [DATA_W-1:0]           data_o
);

  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    // Ascending scan so a later (higher-index) match overrides an earlier one.
    for (int w = 0; w < NUM_WRITE; w++) begin
      if (wr_en_i[w] && (wr_addr_i[slice_lo(w, ADDR_W) +: ADDR_W] == rd_addr_i)) begin
        hit_o  = 1'b1;
        data_o = wr_data_i[slice_lo(w, DATA_W) +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with write bypass, busy scoreboard,
// post-reset clearing sweep and a flattened debug snapshot.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int NREGS     = 32,
  parameter int ADDR_W    = $clog2(NREGS),
  parameter int NUM_READ  = 2,
  parameter int NUM_WRITE = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        ready,
  input  logic [NUM_READ*ADDR_W-1:0]  rd_addr,
  output logic [NUM_READ*DATA_W-1:0]  rd_data,
  output logic [NUM_READ-1:0]         rd_busy,
  input  logic [NUM_WRITE-1:0]        wr_en,
  input  logic [NUM_WRITE*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WRITE*DATA_W-1:0] wr_data,
  input  logic                        busy_set_en,
  input  logic [ADDR_W-1:0]           busy_set_addr,
  output logic [NREGS*DATA_W-1:0]     reg_content
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [DATA_W-1:0] mem_q [NREGS];
  logic [DATA_W-1:0] mem_d [NREGS];
  logic [NREGS-1:0]  busy_q, busy_d;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    mem_d     = mem_q;
    busy_d    = busy_q;
    case (state_q)
      ST_INIT: begin
        mem_d[clr_cnt_q]  = '0;
        busy_d[clr_cnt_q] = 1'b0;
        if (clr_cnt_q == LAST_IDX) begin
          state_d = ST_RUN;
        end else begin
          clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        end
      end
      ST_RUN: begin
        for (int w = 0; w < NUM_WRITE; w++) begin
          if (wr_en[w] && (wr_addr[slice_lo(w, ADDR_W) +: ADDR_W] != '0)) begin
            mem_d[wr_addr[slice_lo(w, ADDR_W) +: ADDR_W]]  = wr_data[slice_lo(w, DATA_W) +: DATA_W];
            busy_d[wr_addr[slice_lo(w, ADDR_W) +: ADDR_W]] = 1'b0;
          end
        end
        // Applied after the clears: a newly issued producer outranks a retiring one.
        if (busy_set_en && (busy_set_addr != '0)) begin
          busy_d[busy_set_addr] = 1'b1;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_INIT;
      clr_cnt_q <= '0;
      busy_q    <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      busy_q    <= busy_d;
      mem_q     <= mem_d;
    end
  end

  assign ready = (state_q == ST_RUN);

  for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              hit;
    logic [DATA_W-1:0] fwd_data;

    assign ra = rd_addr[slice_lo(p, ADDR_W) +: ADDR_W];

    regfile_fwd_sel #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .NUM_WRITE(NUM_WRITE)
    ) u_fwd (
      .rd_addr_i(ra),
      .wr_en_i  (wr_en),
      .wr_addr_i(wr_addr),
      .wr_data_i(wr_data),
      .hit_o    (hit),
      .data_o   (fwd_data)
    );

    // Register 0 and the whole INIT phase read as zero and never busy.
    assign rd_data[slice_lo(p, DATA_W) +: DATA_W] =
      (ready && (ra != '0)) ? (hit ? fwd_data : mem_q[ra]) : '0;
    assign rd_busy[p] = ready && (ra != '0) && busy_q[ra] && !hit;
  end

  for (genvar j = 0; j < NREGS; j++) begin : g_snap
    assign reg_content[slice_lo(j, DATA_W) +: DATA_W] = mem_q[j];
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_regfile_mp;

  localparam int DW  = 32;
  localparam int NR  = 32;
  localparam int AW  = 5;
  localparam int NRD = 2;
  localparam int NWR = 2;

  logic              clk;
  logic              rst;
  logic              ready;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]    rd_busy;
  logic [NWR-1:0]    wr_en;
  logic [NWR*AW-1:0] wr_addr;
  logic [NWR*DW-1:0] wr_data;
  logic              busy_set_en;
  logic [AW-1:0]     busy_set_addr;
  logic [NR*DW-1:0]  reg_content;

  int errors = 0;
  int checks = 0;

  regfile_mp #(
    .DATA_W   (DW),
    .NREGS    (NR),
    .NUM_READ (NRD),
    .NUM_WRITE(NWR)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ready        (ready),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .rd_busy      (rd_busy),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .busy_set_en  (busy_set_en),
    .busy_set_addr(busy_set_addr),
    .reg_content  (reg_content)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [DW-1:0] m_mem [NR];
  bit            m_busy [NR];
  bit            m_ready = 0;
  bit            m_valid = 0;
  int            m_init_cycles = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_valid       = 1;
      m_ready       = 0;
      m_init_cycles = 0;
    end else if (m_valid) begin
      if (!m_ready) begin
        m_init_cycles++;
        if (m_init_cycles == NR) begin
          m_ready = 1;
          for (int i = 0; i < NR; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 0;
          end
        end
      end else begin
        for (int w = 0; w < NWR; w++) begin
          if (wr_en[w] && wr_addr[w*AW +: AW] != 0) begin
            m_mem[wr_addr[w*AW +: AW]]  = wr_data[w*DW +: DW];
            m_busy[wr_addr[w*AW +: AW]] = 0;
          end
        end
        if (busy_set_en && busy_set_addr != 0) m_busy[busy_set_addr] = 1;
      end
    end
  end

  function automatic logic [DW-1:0] exp_rd(input int p);
    logic [AW-1:0] a;
    logic [DW-1:0] r;
    a = rd_addr[p*AW +: AW];
    if (!m_ready || a == 0) return '0;
    r = m_mem[a];
    for (int w = 0; w < NWR; w++)
      if (wr_en[w] && wr_addr[w*AW +: AW] == a) r = wr_data[w*DW +: DW];
    return r;
  endfunction

  function automatic bit exp_busy(input int p);
    logic [AW-1:0] a;
    bit b;
    a = rd_addr[p*AW +: AW];
    if (!m_ready || a == 0) return 0;
    b = m_busy[a];
    for (int w = 0; w < NWR; w++)
      if (wr_en[w] && wr_addr[w*AW +: AW] == a) b = 0;
    return b;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] at %0t: got %h expected %h", name, idx, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    #3;
    if (m_valid) begin
      chk("m_ready", 0, 64'(ready), 64'(m_ready));
      for (int p = 0; p < NRD; p++) begin
        chk("m_rd_data", p, 64'(rd_data[p*DW +: DW]), 64'(exp_rd(p)));
        chk("m_rd_busy", p, 64'(rd_busy[p]), 64'(exp_busy(p)));
      end
      if (m_ready)
        for (int j = 0; j < NR; j++)
          chk("m_reg_content", j, 64'(reg_content[j*DW +: DW]), 64'(m_mem[j]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    wr_en       = '0;
    busy_set_en = 1'b0;
  endtask

  task automatic set_wr(input int w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en[w]            = 1'b1;
    wr_addr[w*AW +: AW] = a;
    wr_data[w*DW +: DW] = d;
  endtask

  task automatic set_rd(input int p, input logic [AW-1:0] a);
    rd_addr[p*AW +: AW] = a;
  endtask

  task automatic set_busy(input logic [AW-1:0] a);
    busy_set_en   = 1'b1;
    busy_set_addr = a;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 7));
    return AW'($urandom_range(0, NR - 1));
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
    busy_set_en = 1'b0; busy_set_addr = '0;
    repeat (3) @(negedge clk);

    // Release reset; writes and busy sets during the sweep must be ignored.
    rst = 1'b0;
    set_wr(0, 5'd9, 32'hABCD1234);
    set_busy(5'd9);
    set_rd(0, 5'd9); set_rd(1, 5'd9);
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      if (k == 32) begin wr_en = '0; busy_set_en = 1'b0; end
      #3;
      chk("ready_seq", k, 64'(ready), (k == 32) ? 64'd1 : 64'd0);
      chk("init_rd_data", k, 64'(rd_data[0 +: DW]), 64'd0);
      chk("init_rd_busy", k, 64'(rd_busy[0]), 64'd0);
    end
    chk("init_write_absent", 9, 64'(reg_content[9*DW +: DW]), 64'd0);

    // r5 write with same-cycle bypass read
    step(); set_wr(0, 5'd5, 32'hDEADBEEF); set_rd(0, 5'd5); #3;
    chk("r5_bypass", 0, 64'(rd_data[0 +: DW]), 64'hDEADBEEF);
    step(); #3;
    chk("r5_snapshot", 5, 64'(reg_content[5*DW +: DW]), 64'hDEADBEEF);

    // Both ports write r7: port 1 wins
    step(); set_wr(0, 5'd7, 32'h11111111); set_wr(1, 5'd7, 32'h22222222); set_rd(1, 5'd7); #3;
    chk("r7_bypass", 1, 64'(rd_data[DW +: DW]), 64'h22222222);
    step(); #3;
    chk("r7_snapshot", 7, 64'(reg_content[7*DW +: DW]), 64'h22222222);

    // Register 0 is hardwired
    step(); set_wr(0, 5'd0, 32'hFFFFFFFF); set_busy(5'd0); set_rd(0, 5'd0); #3;
    chk("r0_rd", 0, 64'(rd_data[0 +: DW]), 64'd0);
    chk("r0_busy", 0, 64'(rd_busy[0]), 64'd0);
    step(); #3;
    chk("r0_rd_after", 0, 64'(rd_data[0 +: DW]), 64'd0);
    chk("r0_busy_after", 0, 64'(rd_busy[0]), 64'd0);
    chk("r0_snapshot", 0, 64'(reg_content[0 +: DW]), 64'd0);

    // Scoreboard sequence on r3
    step(); set_rd(0, 5'd3); set_busy(5'd3); #3;
    chk("sb_set_same", 3, 64'(rd_busy[0]), 64'd0);
    step(); #3;
    chk("sb_set_next", 3, 64'(rd_busy[0]), 64'd1);
    step(); #3;
    chk("sb_hold", 3, 64'(rd_busy[0]), 64'd1);
    step(); set_wr(1, 5'd3, 32'h00000033); #3;
    chk("sb_wr_bypass", 3, 64'(rd_busy[0]), 64'd0);
    chk("sb_wr_data", 3, 64'(rd_data[0 +: DW]), 64'h33);
    step(); #3;
    chk("sb_wr_after", 3, 64'(rd_busy[0]), 64'd0);
    step(); set_busy(5'd3); set_wr(0, 5'd3, 32'h00000044); #3;
    chk("sb_setclr_same", 3, 64'(rd_busy[0]), 64'd0);
    step(); #3;
    chk("sb_set_wins", 3, 64'(rd_busy[0]), 64'd1);
    chk("sb_set_wins_data", 3, 64'(rd_data[0 +: DW]), 64'h44);

    // Fill r1..r4 then reset mid-run
    step(); set_wr(0, 5'd1, 32'hA1); set_wr(1, 5'd2, 32'hA2);
    step(); set_wr(0, 5'd3, 32'hA3); set_wr(1, 5'd4, 32'hA4);
    step(); rst = 1'b1; #3;
    chk("rst_ready_before", 0, 64'(ready), 64'd1);
    step(); rst = 1'b0; #3;
    chk("rst_ready_drop", 0, 64'(ready), 64'd0);
    for (int k = 1; k <= 32; k++) begin
      step(); #3;
      chk("rerun_ready", k, 64'(ready), (k == 32) ? 64'd1 : 64'd0);
    end
    for (int j = 1; j <= 4; j++)
      chk("rerun_cleared", j, 64'(reg_content[j*DW +: DW]), 64'd0);
    set_rd(0, 5'd3); set_rd(1, 5'd4); #1;
    chk("rerun_rd0", 3, 64'(rd_data[0 +: DW]), 64'd0);
    chk("rerun_rd1", 4, 64'(rd_data[DW +: DW]), 64'd0);
    chk("rerun_busy", 3, 64'(rd_busy[0]), 64'd0);

    // Randomized traffic, occasional reset
    for (int i = 0; i < 3000; i++) begin
      step();
      rst = ($urandom_range(0, 499) == 0);
      for (int w = 0; w < NWR; w++)
        if ($urandom_range(0, 2) != 0) set_wr(w, rand_addr(), $urandom);
      if ($urandom_range(0, 2) == 0) set_busy(rand_addr());
      for (int p = 0; p < NRD; p++) set_rd(p, rand_addr());
    end
    step(); rst = 1'b0;
    repeat (4) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
